// File: rtl/mmio_stream_fifo.sv
// mmio_stream_fifo
//   Memory-mapped FIFO bridge. A CPU pushes halfwords through a small register
//   window; the head of the FIFO is presented on a valid/ready stream port.
//   An interrupt fires when the fill level falls to or below a programmable
//   threshold (edge detected, so a stuck-low level raises it only once).
//
// Ports
//   clk_i           system clock
//   reset_i         asynchronous active-high reset
//   write_i/read_i  single-cycle bus strobes
//   addr_i          halfword register index (0 DATA, 1 STATUS, 2 CTRL, 3 IRQ)
//   data_i/data_o   bus write data / registered bus read data (1-cycle latency)
//   stream_data_o   FIFO head word (combinational from the array)
//   stream_valid_o  head word available (stream_en & ~empty)
//   stream_ready_i  consumer accepts the head word
//   int_o           level interrupt (pending & int_en)

module mmio_stream_fifo #(
  parameter int DEPTH_BITS = 4,
  parameter int WIDTH      = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             write_i,
  input  logic             read_i,
  input  logic [1:0]       addr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] stream_data_o,
  output logic             stream_valid_o,
  input  logic             stream_ready_i,
  output logic             int_o
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CW    = DEPTH_BITS + 1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_IRQ    = 2'd3;

  // Storage and state
  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_BITS-1:0] rptr_r;
  logic [DEPTH_BITS-1:0] wptr_r;
  logic [CW-1:0]         count_r;
  logic                  overflow_r;
  logic                  pending_r;
  logic [CW-1:0]         threshold_r;
  logic                  int_en_r;
  logic                  stream_en_r;
  logic                  low_q_r;
  logic [WIDTH-1:0]      data_r;

  // Combinational helpers
  logic                  full_s;
  logic                  empty_s;
  logic                  wr_data_s;
  logic                  wr_status_s;
  logic                  wr_ctrl_s;
  logic                  wr_irq_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  ovf_set_s;
  logic                  low_s;
  logic                  irq_edge_s;
  logic [CW-1:0]         count_nxt_s;
  logic                  pending_nxt_s;
  logic                  overflow_nxt_s;
  logic [WIDTH-1:0]      rd_mux_s;

  assign full_s      = (count_r == CW'(DEPTH));
  assign empty_s     = (count_r == CW'(0));

  assign wr_data_s   = write_i && (addr_i == ADDR_DATA);
  assign wr_status_s = write_i && (addr_i == ADDR_STATUS);
  assign wr_ctrl_s   = write_i && (addr_i == ADDR_CTRL);
  assign wr_irq_s    = write_i && (addr_i == ADDR_IRQ);

  assign stream_valid_o = stream_en_r && !empty_s;
  assign stream_data_o  = mem_r[rptr_r];
  assign int_o          = pending_r && int_en_r;
  assign data_o         = data_r;

  // A pop can only happen when the head is valid, so a push into an empty
  // FIFO never pops in the same cycle.
  assign pop_s     = stream_valid_o && stream_ready_i;
  // When full, a push is still accepted if the same cycle frees a slot.
  assign push_s    = wr_data_s && (!full_s || pop_s);
  assign ovf_set_s = wr_data_s && full_s && !pop_s;

  // A threshold at or above DEPTH keeps low asserted for good.
  assign low_s      = (count_r <= threshold_r);
  assign irq_edge_s = low_s && !low_q_r && int_en_r;

  // Next fill level from push/pop combination
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Sticky flags: a new interrupt edge beats a same-cycle software clear
  always_comb begin
    pending_nxt_s  = pending_r;
    overflow_nxt_s = overflow_r;
    if (irq_edge_s) begin
      pending_nxt_s = 1'b1;
    end else if (wr_irq_s && data_i[0]) begin
      pending_nxt_s = 1'b0;
    end else begin
      pending_nxt_s = pending_r;
    end
    if (ovf_set_s) begin
      overflow_nxt_s = 1'b1;
    end else if (wr_status_s && data_i[WIDTH-1]) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end
  end

  // Register read multiplexer (uses pre-write state for same-cycle writes)
  always_comb begin
    rd_mux_s = '0;
    case (addr_i)
      ADDR_DATA: begin
        rd_mux_s = mem_r[rptr_r];
      end
      ADDR_STATUS: begin
        rd_mux_s[WIDTH-1] = overflow_r;
        rd_mux_s[WIDTH-2] = full_s;
        rd_mux_s[WIDTH-3] = empty_s;
        rd_mux_s[CW-1:0]  = count_r;
      end
      ADDR_CTRL: begin
        rd_mux_s[CW-1:0] = threshold_r;
        rd_mux_s[8]      = int_en_r;
        rd_mux_s[9]      = stream_en_r;
      end
      ADDR_IRQ: begin
        rd_mux_s[0] = pending_r;
      end
      default: begin
        rd_mux_s = '0;
      end
    endcase
  end

  // FIFO array write port; contents are intentionally not reset
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wptr_r] <= data_i;
    end
  end

  // Pointers, fill level and sticky status flags
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_r     <= '0;
      wptr_r     <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
      pending_r  <= 1'b0;
      low_q_r    <= 1'b1;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + DEPTH_BITS'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + DEPTH_BITS'(1);
      end
      count_r    <= count_nxt_s;
      overflow_r <= overflow_nxt_s;
      pending_r  <= pending_nxt_s;
      low_q_r    <= low_s;
    end
  end

  // Control register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      threshold_r <= '0;
      int_en_r    <= 1'b0;
      stream_en_r <= 1'b0;
    end else if (wr_ctrl_s) begin
      threshold_r <= data_i[CW-1:0];
      int_en_r    <= data_i[8];
      stream_en_r <= data_i[9];
    end
  end

  // Bus read data register: captured on the read strobe, held otherwise
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_r <= '0;
    end else if (read_i) begin
      data_r <= rd_mux_s;
    end
  end

endmodule

// File: tb/tb_mmio_stream_fifo.sv
// tb_mmio_stream_fifo
//   Directed stimulus with hand-computed expectations. Stimulus pushes the
//   expected stream words and bus read results into queues; an independent
//   monitor compares them whenever the DUT pops a word or returns read data.

module tb_mmio_stream_fifo;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        write_i;
  logic        read_i;
  logic [1:0]  addr_i;
  logic [15:0] data_i;
  logic [15:0] data_o;
  logic [15:0] stream_data_o;
  logic        stream_valid_o;
  logic        stream_ready_i;
  logic        int_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_stream [$];
  logic [15:0] exp_rd [$];
  bit          rd_pend = 1'b0;

  mmio_stream_fifo #(.DEPTH_BITS(4), .WIDTH(16)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .write_i        (write_i),
    .read_i         (read_i),
    .addr_i         (addr_i),
    .data_i         (data_i),
    .data_o         (data_o),
    .stream_data_o  (stream_data_o),
    .stream_valid_o (stream_valid_o),
    .stream_ready_i (stream_ready_i),
    .int_o          (int_o)
  );

  // Clock: posedge at 5, 15, ...; inputs change on negedges
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit before each posedge
  initial begin
    forever begin
      @(negedge clk_i);
      #4;
      if (rd_pend) begin
        if (exp_rd.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL bus_read: unexpected read result 0x%0h", data_o);
        end else begin
          check("bus_read", data_o, exp_rd.pop_front());
        end
      end
      rd_pend = read_i && !reset_i;
      if (stream_valid_o && stream_ready_i && !reset_i) begin
        if (exp_stream.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL stream_pop: unexpected word 0x%0h", stream_data_o);
        end else begin
          check("stream_pop", stream_data_o, exp_stream.pop_front());
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Called at a negedge; returns at the next negedge with strobes cleared
  task automatic bus_cycle(input logic wr, input logic rd, input logic [1:0] a,
                           input logic [15:0] wd, input logic [15:0] exp);
    write_i = wr;
    read_i  = rd;
    addr_i  = a;
    data_i  = wd;
    if (rd) exp_rd.push_back(exp);
    @(negedge clk_i);
    write_i = 1'b0;
    read_i  = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    bus_cycle(1'b1, 1'b0, a, d, 16'h0000);
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [15:0] exp);
    bus_cycle(1'b0, 1'b1, a, 16'h0000, exp);
  endtask

  task automatic push_word(input logic [15:0] d);
    bus_write(2'd0, d);
    exp_stream.push_back(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // First fill pattern: 0x1111, then 0x0008 .. 0x0016
  function automatic logic [15:0] fill_word(input int i);
    if (i == 0) return 16'h1111;
    else return 16'h0007 + 16'(i);
  endfunction

  initial begin
    reset_i        = 1'b1;
    write_i        = 1'b0;
    read_i         = 1'b0;
    addr_i         = 2'd0;
    data_i         = 16'h0000;
    stream_ready_i = 1'b0;

    // Reset state
    #2;
    check("reset_data_o", data_o, 16'h0000);
    check("reset_valid", stream_valid_o, 1'b0);
    check("reset_int", int_o, 1'b0);
    idle(2);
    reset_i = 1'b0;
    idle(1);
    bus_read(2'd1, 16'h2000);
    bus_read(2'd2, 16'h0000);
    bus_read(2'd3, 16'h0000);

    // Fill / peek with stream disabled
    for (int i = 0; i < 16; i++) push_word(fill_word(i));
    bus_read(2'd1, 16'h4010);
    bus_read(2'd0, 16'h1111);
    check("fill_valid_off", stream_valid_o, 1'b0);

    // Overflow: dropped write, sticky flag, clear via STATUS bit 15
    bus_write(2'd0, 16'hBEEF);
    bus_read(2'd1, 16'hC010);
    bus_write(2'd1, 16'h8000);
    bus_read(2'd1, 16'h4010);

    // Drain with ready held high
    stream_ready_i = 1'b1;
    bus_write(2'd2, 16'h0200);
    idle(18);
    bus_read(2'd1, 16'h2000);
    check("drain_valid", stream_valid_o, 1'b0);
    bus_read(2'd2, 16'h0200);

    // Push into empty FIFO with ready high: no same-cycle pop
    push_word(16'h5555);
    idle(2);
    bus_read(2'd1, 16'h2000);

    // Full push+pop, with a same-cycle DATA read returning the pre-write head
    stream_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) push_word(16'h2000 + 16'(i));
    bus_read(2'd1, 16'h4010);
    check("full_valid", stream_valid_o, 1'b1);
    stream_ready_i = 1'b1;
    bus_cycle(1'b1, 1'b1, 2'd0, 16'hA5A5, 16'h2000);
    exp_stream.push_back(16'hA5A5);
    stream_ready_i = 1'b0;
    bus_read(2'd1, 16'h4010);
    stream_ready_i = 1'b1;
    idle(18);
    stream_ready_i = 1'b0;
    bus_read(2'd1, 16'h2000);

    // Interrupt: threshold 4, int_en
    bus_write(2'd2, 16'h0104);
    for (int i = 0; i < 8; i++) push_word(16'h3000 + 16'(i));
    bus_write(2'd2, 16'h0304);
    bus_read(2'd1, 16'h0008);
    stream_ready_i = 1'b1;
    idle(4);
    stream_ready_i = 1'b0;
    check("int_before_edge", int_o, 1'b0);
    idle(1);
    check("int_after_edge", int_o, 1'b1);
    bus_read(2'd3, 16'h0001);
    bus_write(2'd3, 16'h0001);
    check("int_cleared", int_o, 1'b0);
    push_word(16'h3100);
    idle(1);
    stream_ready_i = 1'b1;
    idle(1);
    stream_ready_i = 1'b0;
    bus_write(2'd3, 16'h0001);
    check("int_set_beats_clear", int_o, 1'b1);
    bus_read(2'd3, 16'h0001);
    bus_write(2'd2, 16'h0204);
    check("int_masked", int_o, 1'b0);
    bus_read(2'd3, 16'h0001);
    stream_ready_i = 1'b1;
    idle(6);
    stream_ready_i = 1'b0;
    bus_write(2'd3, 16'h0001);
    bus_read(2'd3, 16'h0000);
    bus_read(2'd1, 16'h2000);

    // Reset mid-drain with count 7 and an interrupt pending
    bus_write(2'd2, 16'h0308);
    for (int i = 0; i < 9; i++) push_word(16'h4000 + 16'(i));
    stream_ready_i = 1'b1;
    idle(2);
    stream_ready_i = 1'b0;
    check("pre_reset_int", int_o, 1'b1);
    bus_read(2'd1, 16'h0007);
    idle(1);
    stream_ready_i = 1'b1;
    #2;
    reset_i = 1'b1;
    #1;
    check("async_reset_valid", stream_valid_o, 1'b0);
    check("async_reset_int", int_o, 1'b0);
    check("async_reset_data_o", data_o, 16'h0000);
    check("words_buffered_at_reset", exp_stream.size(), 32'd7);
    exp_stream.delete();
    stream_ready_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    idle(1);
    bus_read(2'd1, 16'h2000);
    bus_read(2'd2, 16'h0000);
    bus_read(2'd3, 16'h0000);
    check("post_reset_int", int_o, 1'b0);
    check("post_reset_valid", stream_valid_o, 1'b0);

    idle(3);
    check("stream_queue_drained", exp_stream.size(), 32'd0);
    check("read_queue_drained", exp_rd.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
